// File: rtl/synth_pulse_pkg.sv
// Shared definitions for the synthesizer pulse blocks: strobe FSM states and
// default timing constants also used by the edge-detector benches.
package synth_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACTIVE  = 2'b01,
        RECOVER = 2'b10
    } pulse_state_e;

    localparam int DEF_PULSE_LEN = 4;
    localparam int DEF_GAP_LEN   = 2;
    localparam int DEF_CNT_W     = 8;

    // A zero-length strobe would produce no falling edge, so it is stretched to one cycle.
    function automatic int effPulseLen(input int len);
        return (len < 1) ? 1 : len;
    endfunction

endpackage

// File: rtl/neg_pulse_gen_if.sv
// Trigger/strobe bundle between a pulse requester (master) and neg_pulse_gen (slave).
interface neg_pulse_gen_if
    import synth_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             trig;
    logic             wn;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] drop_cnt;

    modport master (output trig, input wn, input busy, input done, input drop_cnt);
    modport slave  (input trig, output wn, output busy, output done, output drop_cnt);

endinterface

// File: rtl/neg_pulse_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/neg_pulse_gen.sv
// Turns a one-cycle trigger into an active-low strobe of PULSE_LEN cycles
// followed by a GAP_LEN-cycle high recovery window; ignored triggers are counted.
module neg_pulse_gen
    import synth_pulse_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter bit RETRIG    = 1'b0,
    parameter int CNT_W     = DEF_CNT_W
) (
    input logic            clk,
    input logic            rst,
    neg_pulse_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] PLEN_C = CNT_W'(effPulseLen(PULSE_LEN));
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_LEN);

    pulse_state_e     state_q;
    pulse_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wn_q;
    logic             wn_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             dropInc;
    logic [CNT_W-1:0] dropCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wn_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wn_q    <= wn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The counter holds the cycles remaining in the current phase, including this one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dropInc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.trig) begin
                    state_d = ACTIVE;
                    cnt_d   = PLEN_C;
                end
            end
            ACTIVE: begin
                if (bus.trig && RETRIG) begin
                    cnt_d = PLEN_C;
                end else begin
                    dropInc = bus.trig;
                    if (cnt_q <= CNT_W'(1)) begin
                        if (GAP_LEN == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RECOVER;
                            cnt_d   = GAP_C;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            RECOVER: begin
                dropInc = bus.trig;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        wn_d   = (state_d != ACTIVE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == IDLE) && ((state_q == ACTIVE) || (state_q == RECOVER));
    end

    sat_counter #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk_i(clk),
        .clr_i(rst),
        .inc_i(dropInc),
        .cnt_o(dropCount)
    );

    assign bus.wn       = wn_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.drop_cnt = dropCount;

endmodule

// File: tb/tb_neg_pulse_gen.sv
// Drives four neg_pulse_gen configurations from one trigger/reset stream and
// compares every cycle against a timeline model of pulse windows and drop counts.
module tb_neg_pulse_gen;
    import synth_pulse_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig = 1'b0;

    always #5 clk = ~clk;

    neg_pulse_gen_if #(.CNT_W(8)) ifA ();
    neg_pulse_gen_if #(.CNT_W(8)) ifB ();
    neg_pulse_gen_if #(.CNT_W(8)) ifC ();
    neg_pulse_gen_if #(.CNT_W(2)) ifD ();

    assign ifA.trig = trig;
    assign ifB.trig = trig;
    assign ifC.trig = trig;
    assign ifD.trig = trig;

    neg_pulse_gen #(.PULSE_LEN(4), .GAP_LEN(2), .RETRIG(1'b0), .CNT_W(8))
        dutA (.clk(clk), .rst(rst), .bus(ifA));
    neg_pulse_gen #(.PULSE_LEN(4), .GAP_LEN(2), .RETRIG(1'b1), .CNT_W(8))
        dutB (.clk(clk), .rst(rst), .bus(ifB));
    neg_pulse_gen #(.PULSE_LEN(4), .GAP_LEN(0), .RETRIG(1'b0), .CNT_W(8))
        dutC (.clk(clk), .rst(rst), .bus(ifC));
    neg_pulse_gen #(.PULSE_LEN(3), .GAP_LEN(1), .RETRIG(1'b0), .CNT_W(2))
        dutD (.clk(clk), .rst(rst), .bus(ifD));

    int pLen[4]    = '{4, 4, 4, 3};
    int gLen[4]    = '{2, 2, 0, 1};
    int reTrig[4]  = '{0, 1, 0, 0};
    int maxDrop[4] = '{255, 255, 255, 3};

    // Model state: each pulse is a window of cycle numbers, not a counter.
    int startC[4];
    int lowEnd[4];
    int busyEnd[4];
    int drops[4];
    int accepts[4];
    int falls[4];
    logic prevWn[4];

    int cyc;
    int checks;
    int errors;

    function automatic bit inActive(input int i, input int c);
        return (c >= startC[i]) && (c <= lowEnd[i]);
    endfunction

    function automatic bit inBusy(input int i, input int c);
        return (c >= startC[i]) && (c <= busyEnd[i]);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelEdge(input int e, input logic t, input logic r);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                startC[i]  = -10;
                lowEnd[i]  = -10;
                busyEnd[i] = -10;
                drops[i]   = 0;
            end else if (t) begin
                if (!inBusy(i, e)) begin
                    startC[i]  = e + 1;
                    lowEnd[i]  = e + pLen[i];
                    busyEnd[i] = e + pLen[i] + gLen[i];
                    accepts[i]++;
                end else if (inActive(i, e) && (reTrig[i] != 0)) begin
                    lowEnd[i]  = e + pLen[i];
                    busyEnd[i] = e + pLen[i] + gLen[i];
                end else if (drops[i] < maxDrop[i]) begin
                    drops[i]++;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic obsWn[4];
        logic obsBusy[4];
        logic obsDone[4];
        logic [31:0] obsDrop[4];
        obsWn[0] = ifA.wn;   obsBusy[0] = ifA.busy; obsDone[0] = ifA.done; obsDrop[0] = 32'(ifA.drop_cnt);
        obsWn[1] = ifB.wn;   obsBusy[1] = ifB.busy; obsDone[1] = ifB.done; obsDrop[1] = 32'(ifB.drop_cnt);
        obsWn[2] = ifC.wn;   obsBusy[2] = ifC.busy; obsDone[2] = ifC.done; obsDrop[2] = 32'(ifC.drop_cnt);
        obsWn[3] = ifD.wn;   obsBusy[3] = ifD.busy; obsDone[3] = ifD.done; obsDrop[3] = 32'(ifD.drop_cnt);
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("wn[%0d]@%0d", i, cyc), 32'(obsWn[i]), 32'(!inActive(i, cyc)));
            checkVal($sformatf("busy[%0d]@%0d", i, cyc), 32'(obsBusy[i]), 32'(inBusy(i, cyc)));
            checkVal($sformatf("done[%0d]@%0d", i, cyc), 32'(obsDone[i]), 32'(cyc == busyEnd[i] + 1));
            checkVal($sformatf("drop[%0d]@%0d", i, cyc), obsDrop[i], 32'(drops[i]));
            if ((prevWn[i] === 1'b1) && (obsWn[i] === 1'b0)) begin
                falls[i]++;
            end
            prevWn[i] = obsWn[i];
        end
    endtask

    task automatic applyStimulus(input logic t, input logic r);
        @(negedge clk);
        trig = t;
        rst  = r;
        @(posedge clk);
        modelEdge(cyc, t, r);
        cyc++;
        #1;
        checkOutput();
    endtask

    task automatic idleFor(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) begin
            startC[i]  = -10;
            lowEnd[i]  = -10;
            busyEnd[i] = -10;
            drops[i]   = 0;
            accepts[i] = 0;
            falls[i]   = 0;
            prevWn[i]  = 1'bx;
        end

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        idleFor(5);

        $display("[TB] single trigger");
        applyStimulus(1'b1, 1'b0);
        idleFor(10);

        $display("[TB] triggers at +0, +2, +5");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleFor(10);

        $display("[TB] triggers at +0, +3");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleFor(12);

        $display("[TB] trigger held high");
        repeat (20) applyStimulus(1'b1, 1'b0);
        idleFor(8);

        $display("[TB] reset during active pulse");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        idleFor(10);

        $display("[TB] drop counter saturation");
        repeat (8) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
        end
        idleFor(8);

        $display("[TB] random stimulus");
        repeat (400) begin
            applyStimulus(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 80) == 0));
        end
        idleFor(10);

        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("fallingEdges[%0d]", i), 32'(falls[i]), 32'(accepts[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neg_pulse_gen.md
# neg_pulse_gen

Converts a single-cycle trigger into a clean active-low strobe of programmable width, followed by a guaranteed high recovery gap. It is the transmit-side counterpart of the synthesizer's falling-edge detector. It drives key and gate lines, either in simulation or toward internal note logic, so each request appears downstream as exactly one falling edge. It sits between control logic (sequencer, test stimulus) and any consumer that detects falling edges.

## Interface
- PULSE_LEN, 4, cycles `wn` is held low per accepted trigger; 0 is treated as 1
- GAP_LEN, 2, minimum cycles `wn` is held high after a pulse before a new trigger is accepted; 0 allowed
- RETRIG, 0, 0: triggers during ACTIVE are dropped; 1: triggers during ACTIVE reload the low-count
- CNT_W, 8, width of internal length counters and of `drop_cnt`
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- trig  in  1  pulse request, sampled every rising edge
- wn  out  1  active-low strobe, registered; reset value 1
- busy  out  1  high in ACTIVE or RECOVER; reset value 0
- done  out  1  one-cycle pulse on the first IDLE cycle after a pulse/gap completes; reset value 0
- drop_cnt  out  CNT_W  saturating count of ignored triggers; reset value 0

## Operation
- States: IDLE (00), ACTIVE (01), RECOVER (10); 11 is unreachable and recovers to IDLE on the next edge.
- IDLE: `wn`=1. On `trig`=1, load the counter with max(PULSE_LEN,1) and go to ACTIVE.
- ACTIVE: `wn`=0. Decrement each cycle. On reaching the last cycle, go to RECOVER with the counter loaded to GAP_LEN, or go to IDLE if GAP_LEN=0.
- RECOVER: `wn`=1. Decrement each cycle. Go to IDLE after GAP_LEN cycles.
- `trig` in ACTIVE with RETRIG=1: reload the counter to PULSE_LEN. `wn` stays low for PULSE_LEN cycles counted from the retrigger edge. Not counted as a drop.
- `trig` in ACTIVE with RETRIG=0, or `trig` in RECOVER (either mode): ignored; `drop_cnt` increments, saturating at 2^CNT_W−1.
- `done`: asserted exactly in the first IDLE cycle following ACTIVE/RECOVER. A `trig` in that same cycle is accepted.
- Reset mid-operation: on the next edge `wn`=1, state IDLE, counters 0, `drop_cnt`=0, `done`=0. No partial pulse is resumed.

## Timing
- `trig` high at edge t (IDLE) → `wn` low from t+1 through t+PULSE_LEN, high at t+PULSE_LEN+1.
- `busy` follows state: high from t+1 through t+PULSE_LEN+GAP_LEN.
- `done` high at cycle t+PULSE_LEN+GAP_LEN+1.
- Minimum trigger-to-trigger spacing for acceptance is PULSE_LEN+GAP_LEN+1 cycles.
- Even with GAP_LEN=0, `wn` is high for at least 1 cycle between pulses, so every accepted trigger yields a distinct falling edge.
- No combinational path from `trig` to any output.

## Structure
- Shared package `synth_pulse_pkg` holds:
  - state typedef and encodings (IDLE/ACTIVE/RECOVER)
  - default PULSE_LEN/GAP_LEN constants, shared with the edge-detector testbenches
- One natural sub-module: `sat_counter`, a CNT_W-bit saturating incrementer with synchronous clear, used for `drop_cnt`.
- Length down-counter and FSM stay in the top module.

## Test plan
- PULSE_LEN=4, GAP_LEN=2: single `trig` at cycle 10 → `wn`=0 cycles 11–14, `busy` cycles 11–16, `done` at cycle 17, `drop_cnt`=0.
- RETRIG=0: triggers at cycles 10, 12, 15 → one pulse (cycles 11–14); `drop_cnt`=2 (cycle 12 in ACTIVE, cycle 15 in RECOVER).
- RETRIG=1: triggers at cycles 10 and 13 → `wn` low cycles 11–17; `drop_cnt`=0; `done` at cycle 20.
- GAP_LEN=0, `trig` held high continuously → `wn` repeats pattern of 4 low, 1 high; an edge detector on `wn` ticks once per pulse.
- `rst` asserted at cycle 12 during ACTIVE → `wn`=1, `busy`=0, `drop_cnt`=0 from cycle 13; `trig` at cycle 14 yields a full 4-cycle pulse.
- CNT_W=2, RETRIG=0: 5 dropped triggers → `drop_cnt` saturates at 3 and holds.
